// File: rtl/array_alu_pl_pkg.sv
// Shared definitions for the pipelined cache-line ALU: op encoding,
// lane-count derivation and lane-range limit helpers.
package array_alu_pl_pkg;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_MIN = 2'b10,
    OP_MAX = 2'b11
  } op_e;

  // Number of independent lanes in one cache line.
  function automatic int calc_lanes(input int cache_width, input int data_width);
    return cache_width / data_width;
  endfunction

  // Largest representable lane value, zero-extended to 64 bits.
  function automatic logic [63:0] lane_hi(input int data_width, input bit is_signed);
    logic [63:0] all_ones;
    all_ones = '1;
    if (is_signed) return all_ones >> (65 - data_width);
    return all_ones >> (64 - data_width);
  endfunction

  // Smallest representable lane value; only the low data_width bits matter.
  function automatic logic [63:0] lane_lo(input int data_width, input bit is_signed);
    if (is_signed) return 64'd1 << (data_width - 1);
    return 64'd0;
  endfunction

endpackage

// File: rtl/array_alu_pl_lane.sv
// One lane of the cache-line ALU: add/sub with overflow detection and
// optional clamping, plus min/max. Purely combinational.
module array_alu_lane
  import array_alu_pl_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter bit SIGNED     = 1'b0,
  parameter bit SATURATE   = 1'b0
) (
  input  op_e                   op,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  output logic [DATA_WIDTH-1:0] res,
  output logic                  ovf
);

  localparam int              W    = DATA_WIDTH;
  localparam logic [63:0]     HI64 = lane_hi(W, SIGNED);
  localparam logic [63:0]     LO64 = lane_lo(W, SIGNED);
  localparam logic [W-1:0]    HI   = HI64[W-1:0];
  localparam logic [W-1:0]    LO   = LO64[W-1:0];

  logic [W:0] sum;
  logic [W:0] diff;
  logic       add_ovf;
  logic       sub_ovf;
  logic       a_lt_b;
  logic       b_lt_a;

  // One extra bit holds the unsigned carry/borrow.
  assign sum  = {1'b0, a} + {1'b0, b};
  assign diff = {1'b0, a} - {1'b0, b};

  // Signed overflow: result sign disagrees with what the operand signs allow.
  assign add_ovf = SIGNED ? ((a[W-1] == b[W-1]) && (sum[W-1]  != a[W-1])) : sum[W];
  assign sub_ovf = SIGNED ? ((a[W-1] != b[W-1]) && (diff[W-1] != a[W-1])) : diff[W];

  assign a_lt_b = SIGNED ? ($signed(a) < $signed(b)) : (a < b);
  assign b_lt_a = SIGNED ? ($signed(b) < $signed(a)) : (b < a);

  // Select the op result; on signed overflow the clamp direction follows a's sign.
  always_comb begin
    // NOTE: every output gets a default first so no path can infer a latch.
    res = a;
    ovf = 1'b0;
    unique case (op)
      OP_ADD: begin
        ovf = add_ovf;
        res = sum[W-1:0];
        if (SATURATE && add_ovf) res = (SIGNED && a[W-1]) ? LO : HI;
      end
      OP_SUB: begin
        ovf = sub_ovf;
        res = diff[W-1:0];
        if (SATURATE && sub_ovf) res = (!SIGNED || a[W-1]) ? LO : HI;
      end
      OP_MIN: res = b_lt_a ? b : a;
      OP_MAX: res = a_lt_b ? b : a;
      default: res = a;
    endcase
  end

endmodule

// File: rtl/array_alu_pl.sv
// Pipelined element-wise ALU over two cache lines with valid/ready flow
// control. Stage 0 computes, later stages delay; empty stages are refilled
// even while downstream is stalled.
module array_alu_pl
  import array_alu_pl_pkg::*;
#(
  parameter int CACHE_WIDTH = 512,
  parameter int DATA_WIDTH  = 32,
  parameter int PIPE_STAGES = 2,
  parameter bit SIGNED      = 1'b0,
  parameter bit SATURATE    = 1'b0,
  localparam int LANES      = calc_lanes(CACHE_WIDTH, DATA_WIDTH)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [1:0]             in_op,
  input  logic [CACHE_WIDTH-1:0] in_a,
  input  logic [CACHE_WIDTH-1:0] in_b,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [CACHE_WIDTH-1:0] out_res,
  output logic [LANES-1:0]       out_ovf,
  output logic [31:0]            beat_cnt
);

  logic [PIPE_STAGES-1:0] vld;
  logic [PIPE_STAGES-1:0] load;
  logic [CACHE_WIDTH-1:0] res_q [PIPE_STAGES];
  logic [LANES-1:0]       ovf_q [PIPE_STAGES];
  logic [CACHE_WIDTH-1:0] lane_res;
  logic [LANES-1:0]       lane_ovf;
  logic                   ready_q;
  logic                   full_from;
  logic                   accept;

  // Stage-0 compute: one independent lane ALU per DATA_WIDTH slice.
  for (genvar i = 0; i < LANES; i++) begin : g_lane
    array_alu_lane #(
      .DATA_WIDTH(DATA_WIDTH),
      .SIGNED    (SIGNED),
      .SATURATE  (SATURATE)
    ) u_lane (
      .op (op_e'(in_op)),
      .a  (in_a[i*DATA_WIDTH +: DATA_WIDTH]),
      .b  (in_b[i*DATA_WIDTH +: DATA_WIDTH]),
      .res(lane_res[i*DATA_WIDTH +: DATA_WIDTH]),
      .ovf(lane_ovf[i])
    );
  end

  // Hold off input for the first cycle after reset release.
  always_ff @(posedge clk or negedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (!rst) ready_q <= 1'b0;
    else      ready_q <= 1'b1;
  end

  // Stage k may load unless it and every stage after it is full while the
  // output is stalled; written in closed form to avoid a combinational chain
  // on one vector.
  always_comb begin
    load      = '0;
    full_from = 1'b1;
    for (int k = 0; k < PIPE_STAGES; k++) begin
      full_from = 1'b1;
      for (int j = k; j < PIPE_STAGES; j++) full_from = full_from & vld[j];
      load[k] = out_ready | ~full_from;
    end
  end

  assign in_ready = ready_q & load[0];
  assign accept   = in_valid & in_ready;

  // Pipeline registers: valid bits move with their data; a stage whose
  // upstream neighbour is empty becomes a bubble when it loads.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld <= '0;
      // NOTE: data registers are cleared too, so a reset leaves out_res/out_ovf at zero.
      for (int k = 0; k < PIPE_STAGES; k++) begin
        res_q[k] <= '0;
        ovf_q[k] <= '0;
      end
    end else begin
      if (load[0]) begin
        vld[0] <= accept;
        if (accept) begin
          res_q[0] <= lane_res;
          ovf_q[0] <= lane_ovf;
        end
      end
      for (int k = 1; k < PIPE_STAGES; k++) begin
        if (load[k]) begin
          vld[k] <= vld[k-1];
          if (vld[k-1]) begin
            res_q[k] <= res_q[k-1];
            ovf_q[k] <= ovf_q[k-1];
          end
        end
      end
    end
  end

  // Count completed output transfers, wrapping naturally at 2^32.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                        beat_cnt <= '0;
    else if (out_valid && out_ready) beat_cnt <= beat_cnt + 32'd1;
  end

  assign out_valid = vld[PIPE_STAGES-1];
  assign out_res   = res_q[PIPE_STAGES-1];
  assign out_ovf   = ovf_q[PIPE_STAGES-1];

endmodule

// File: tb/tb_array_alu_pl.sv
// Self-checking bench for array_alu_pl: four instances (unsigned wrap,
// unsigned saturate, signed saturate, 4-stage unsigned wrap) checked by a
// lane-level arithmetic reference model, hand-computed vectors and
// multi-cycle flow-control sequences.
module tb_array_alu_pl;

  localparam int CW = 512;
  localparam int DW = 32;
  localparam int L  = CW / DW;
  localparam int ND = 4;

  typedef struct {
    logic [CW-1:0] res;
    logic [L-1:0]  ovf;
  } exp_t;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a0;
    logic [31:0] b0;
    logic [31:0] r_wrap;  logic o_wrap;
    logic [31:0] r_usat;  logic o_usat;
    logic [31:0] r_ssat;  logic o_ssat;
  } vec_t;

  logic          clk;
  logic          rst;
  logic          in_valid, out_ready, p4_valid, p4_ready;
  logic [1:0]    in_op;
  logic [CW-1:0] in_a, in_b;
  logic          in_ready_w  [ND];
  logic          out_valid_w [ND];
  logic [CW-1:0] res_w       [ND];
  logic [L-1:0]  ovf_w       [ND];
  logic [31:0]   cnt_w       [ND];

  int   tests = 0;
  int   fails = 0;
  exp_t exp_q [ND][$];
  bit   sgn_c [ND] = '{1'b0, 1'b0, 1'b1, 1'b0};
  bit   sat_c [ND] = '{1'b0, 1'b1, 1'b1, 1'b0};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  array_alu_pl #(.PIPE_STAGES(2), .SIGNED(1'b0), .SATURATE(1'b0)) u_def (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_w[0]),
    .in_op(in_op), .in_a(in_a), .in_b(in_b), .out_valid(out_valid_w[0]),
    .out_ready(out_ready), .out_res(res_w[0]), .out_ovf(ovf_w[0]), .beat_cnt(cnt_w[0]));

  array_alu_pl #(.PIPE_STAGES(2), .SIGNED(1'b0), .SATURATE(1'b1)) u_usat (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_w[1]),
    .in_op(in_op), .in_a(in_a), .in_b(in_b), .out_valid(out_valid_w[1]),
    .out_ready(out_ready), .out_res(res_w[1]), .out_ovf(ovf_w[1]), .beat_cnt(cnt_w[1]));

  array_alu_pl #(.PIPE_STAGES(2), .SIGNED(1'b1), .SATURATE(1'b1)) u_ssat (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_w[2]),
    .in_op(in_op), .in_a(in_a), .in_b(in_b), .out_valid(out_valid_w[2]),
    .out_ready(out_ready), .out_res(res_w[2]), .out_ovf(ovf_w[2]), .beat_cnt(cnt_w[2]));

  array_alu_pl #(.PIPE_STAGES(4), .SIGNED(1'b0), .SATURATE(1'b0)) u_p4 (
    .clk(clk), .rst(rst), .in_valid(p4_valid), .in_ready(in_ready_w[3]),
    .in_op(in_op), .in_a(in_a), .in_b(in_b), .out_valid(out_valid_w[3]),
    .out_ready(p4_ready), .out_res(res_w[3]), .out_ovf(ovf_w[3]), .beat_cnt(cnt_w[3]));

  task automatic check(input string name, input logic [CW-1:0] act, input logic [CW-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: each lane as a plain integer, range-checked against the lane limits.
  function automatic exp_t model(input logic [1:0] op, input logic [CW-1:0] a,
                                 input logic [CW-1:0] b, input bit sgn, input bit sat);
    exp_t        e;
    longint      av, bv, r, lo, hi;
    logic [31:0] al, bl;
    bit          o;
    lo = sgn ? -(longint'(1) << 31) : 64'sd0;
    hi = sgn ? (longint'(1) << 31) - 1 : (longint'(1) << 32) - 1;
    e.res = '0;
    e.ovf = '0;
    for (int i = 0; i < L; i++) begin
      al = a[i*DW +: DW];
      bl = b[i*DW +: DW];
      av = sgn ? longint'($signed(al)) : longint'({32'd0, al});
      bv = sgn ? longint'($signed(bl)) : longint'({32'd0, bl});
      case (op)
        2'd0:    r = av + bv;
        2'd1:    r = av - bv;
        2'd2:    r = (bv < av) ? bv : av;
        default: r = (bv > av) ? bv : av;
      endcase
      o = (op < 2'd2) && (r < lo || r > hi);
      if (o && sat) r = (r < lo) ? lo : hi;
      e.res[i*DW +: DW] = r[31:0];
      e.ovf[i] = o;
    end
    return e;
  endfunction

  // Scoreboard: samples handshakes mid-cycle, predicts on input transfer,
  // compares on output transfer; reset discards everything in flight.
  always @(negedge clk) begin
    #4;
    for (int d = 0; d < ND; d++) begin
      logic iv, orr;
      exp_t e;
      iv  = (d == 3) ? p4_valid : in_valid;
      orr = (d == 3) ? p4_ready : out_ready;
      if (!rst) begin
        exp_q[d].delete();
      end else begin
        if (out_valid_w[d] && orr) begin
          if (exp_q[d].size() == 0) begin
            tests++;
            fails++;
            $display("FAIL sb%0d_spurious: got an output beat, expected none", d);
          end else begin
            e = exp_q[d].pop_front();
            check($sformatf("sb%0d_res", d), res_w[d], e.res);
            check($sformatf("sb%0d_ovf", d), CW'(ovf_w[d]), CW'(e.ovf));
          end
        end
        if (iv && in_ready_w[d]) exp_q[d].push_back(model(in_op, in_a, in_b, sgn_c[d], sat_c[d]));
      end
    end
  end

  function automatic logic [31:0] rand_lane();
    case ($urandom_range(0, 5))
      0:       return 32'h0000_0000;
      1:       return 32'h0000_0001;
      2:       return 32'h7FFF_FFFF;
      3:       return 32'h8000_0000;
      4:       return 32'hFFFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  // Present one beat to the PIPE_STAGES=2 instances and hold it until accepted.
  task automatic send_one(input logic [1:0] op, input logic [CW-1:0] a, input logic [CW-1:0] b);
    bit ok;
    ok = 1'b0;
    @(negedge clk);
    in_valid = 1'b1; in_op = op; in_a = a; in_b = b;
    for (int t = 0; t < 50 && !ok; t++) begin
      #4;
      if (in_ready_w[0]) ok = 1'b1;
      @(negedge clk);
    end
    in_valid = 1'b0;
    if (!ok) begin
      tests++; fails++;
      $display("FAIL send_timeout: in_ready stayed 0, expected 1 within 50 cycles");
    end
  endtask

  // Wait (bounded) until instance d shows out_valid; returns at mid-cycle.
  task automatic wait_out(input int d);
    bit ok;
    ok = 1'b0;
    for (int t = 0; t < 50 && !ok; t++) begin
      #4;
      if (out_valid_w[d]) ok = 1'b1;
      else @(negedge clk);
    end
    if (!ok) begin
      tests++; fails++;
      $display("FAIL wait_out%0d: out_valid stayed 0, expected 1 within 50 cycles", d);
    end
  endtask

  vec_t vecs [8];

  initial begin
    logic [CW-1:0] a, b, exp_line;
    logic [31:0]   l1;
    bit            acc;
    int            sent, seen;

    vecs[0] = '{2'd0, 32'hFFFF_FFFF, 32'h2,         32'h1,         1, 32'hFFFF_FFFF, 1, 32'h1,         0};
    vecs[1] = '{2'd1, 32'h8000_0000, 32'h1,         32'h7FFF_FFFF, 0, 32'h7FFF_FFFF, 0, 32'h8000_0000, 1};
    vecs[2] = '{2'd2, 32'hFFFF_FFFD, 32'h4,         32'h4,         0, 32'h4,         0, 32'hFFFF_FFFD, 0};
    vecs[3] = '{2'd3, 32'hFFFF_FFFD, 32'h4,         32'hFFFF_FFFD, 0, 32'hFFFF_FFFD, 0, 32'h4,         0};
    vecs[4] = '{2'd1, 32'h3,         32'h5,         32'hFFFF_FFFE, 1, 32'h0,         1, 32'hFFFF_FFFE, 0};
    vecs[5] = '{2'd0, 32'h7FFF_FFFF, 32'h1,         32'h8000_0000, 0, 32'h8000_0000, 0, 32'h7FFF_FFFF, 1};
    vecs[6] = '{2'd2, 32'h9,         32'h9,         32'h9,         0, 32'h9,         0, 32'h9,         0};
    vecs[7] = '{2'd1, 32'h0,         32'h8000_0000, 32'h8000_0000, 1, 32'h0,         1, 32'h7FFF_FFFF, 1};

    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1; p4_valid = 1'b0; p4_ready = 1'b1;
    in_op = 2'd0; in_a = '0; in_b = '0;

    // Reset state.
    repeat (3) @(negedge clk);
    #1;
    check("rst_out_valid", CW'(out_valid_w[0]), CW'(0));
    check("rst_beat_cnt",  CW'(cnt_w[0]), CW'(0));
    check("rst_out_res",   res_w[0], '0);
    check("rst_out_ovf",   CW'(ovf_w[0]), CW'(0));
    check("rst_in_ready",  CW'(in_ready_w[0]), CW'(0));
    @(negedge clk);
    rst = 1'b1;
    #1 check("ready_before_edge", CW'(in_ready_w[0]), CW'(0));
    @(posedge clk);
    #1 check("ready_after_edge", CW'(in_ready_w[0]), CW'(1));

    // Add with defaults: all lanes 5 + 7, latency two cycles.
    for (int i = 0; i < L; i++) begin a[i*DW +: DW] = 32'd5; b[i*DW +: DW] = 32'd7; end
    for (int i = 0; i < L; i++) exp_line[i*DW +: DW] = 32'd12;
    send_one(2'd0, a, b);
    #1 check("lat_cycle1_valid", CW'(out_valid_w[0]), CW'(0));
    @(posedge clk);
    #1;
    check("lat_cycle2_valid", CW'(out_valid_w[0]), CW'(1));
    check("add_res", res_w[0], exp_line);
    check("add_ovf", CW'(ovf_w[0]), CW'(0));
    @(posedge clk);
    #1 check("add_beat_cnt", CW'(cnt_w[0]), CW'(1));

    // Hand-computed lane-0 vectors; other lanes carry a = b = 0x100.
    foreach (vecs[v]) begin
      for (int i = 0; i < L; i++) begin a[i*DW +: DW] = 32'h100; b[i*DW +: DW] = 32'h100; end
      a[31:0] = vecs[v].a0;
      b[31:0] = vecs[v].b0;
      l1 = (vecs[v].op == 2'd0) ? 32'h200 : (vecs[v].op == 2'd1) ? 32'h0 : 32'h100;
      send_one(vecs[v].op, a, b);
      wait_out(0);
      check($sformatf("vec%0d_wrap_res", v), CW'(res_w[0][31:0]), CW'(vecs[v].r_wrap));
      check($sformatf("vec%0d_wrap_ovf", v), CW'(ovf_w[0][0]),    CW'(vecs[v].o_wrap));
      check($sformatf("vec%0d_usat_res", v), CW'(res_w[1][31:0]), CW'(vecs[v].r_usat));
      check($sformatf("vec%0d_usat_ovf", v), CW'(ovf_w[1][0]),    CW'(vecs[v].o_usat));
      check($sformatf("vec%0d_ssat_res", v), CW'(res_w[2][31:0]), CW'(vecs[v].r_ssat));
      check($sformatf("vec%0d_ssat_ovf", v), CW'(ovf_w[2][0]),    CW'(vecs[v].o_ssat));
      check($sformatf("vec%0d_lane1", v),    CW'(res_w[0][63:32]), CW'(l1));
      check($sformatf("vec%0d_ovf_hi", v),   CW'(ovf_w[2][L-1:1]), CW'(0));
    end

    // Randomised traffic with random backpressure, checked by the scoreboard.
    acc = 1'b0;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      if (!in_valid || acc) begin
        in_valid = ($urandom_range(0, 3) != 0);
        in_op    = 2'($urandom_range(0, 3));
        for (int i = 0; i < L; i++) begin in_a[i*DW +: DW] = rand_lane(); in_b[i*DW +: DW] = rand_lane(); end
      end
      out_ready = ($urandom_range(0, 3) != 0);
      #4 acc = in_valid && in_ready_w[0];
    end
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (6) @(negedge clk);
    for (int d = 0; d < 3; d++) check($sformatf("rand_drain%0d", d), CW'(exp_q[d].size()), CW'(0));

    // Async reset with beats in flight: 3 beats into the 4-stage instance.
    @(negedge clk);
    in_op = 2'd0; p4_ready = 1'b1; out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      in_valid = 1'b1; p4_valid = 1'b1;
      for (int i = 0; i < L; i++) begin in_a[i*DW +: DW] = 32'(k + 1); in_b[i*DW +: DW] = 32'(i); end
      @(negedge clk);
    end
    #2 rst = 1'b0;
    in_valid = 1'b0; p4_valid = 1'b0;
    #1;
    check("arst_out_valid_p2", CW'(out_valid_w[0]), CW'(0));
    check("arst_out_valid_p4", CW'(out_valid_w[3]), CW'(0));
    check("arst_cnt_p2",       CW'(cnt_w[0]), CW'(0));
    check("arst_cnt_p4",       CW'(cnt_w[3]), CW'(0));
    check("arst_in_ready",     CW'(in_ready_w[3]), CW'(0));
    repeat (2) @(negedge clk);
    rst = 1'b1;
    seen = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      #4 if (out_valid_w[0] || out_valid_w[3]) seen++;
    end
    check("arst_no_stale", CW'(seen), CW'(0));

    // Backpressure: 8 beats, out_ready low for cycles 3..10.
    sent = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      out_ready = !(c >= 3 && c <= 10);
      in_valid  = (sent < 8);
      in_op     = 2'd0;
      for (int i = 0; i < L; i++) begin in_a[i*DW +: DW] = 32'(sent * 16 + i); in_b[i*DW +: DW] = 32'd1; end
      #4;
      if (c == 10) check("bp_full_ready", CW'(in_ready_w[0]), CW'(0));
      if (c == 11) check("bp_no_dead_cycle", CW'(in_ready_w[0]), CW'(1));
      if (in_valid && in_ready_w[0]) sent++;
    end
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1;
    #1;
    check("bp_sent", CW'(sent), CW'(8));
    check("bp_beat_cnt", CW'(cnt_w[0]), CW'(8));
    check("bp_drain", CW'(exp_q[0].size()), CW'(0));

    // Bubble collapse in the 4-stage instance with the output stalled.
    p4_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      if (k == 2) repeat (6) begin @(negedge clk); p4_valid = 1'b0; end
      @(negedge clk);
      p4_valid = 1'b1; in_op = 2'd3;
      for (int i = 0; i < L; i++) begin in_a[i*DW +: DW] = 32'(k * 100 + i); in_b[i*DW +: DW] = 32'(50 * k); end
      #4;
      if (k == 2) check("bub_packed_valid", CW'(out_valid_w[3]), CW'(1));
      check($sformatf("bub_ready%0d", k), CW'(in_ready_w[3]), CW'(k < 4 ? 1 : 0));
      @(negedge clk);
      p4_valid = 1'b0;
    end
    p4_ready = 1'b1;
    repeat (8) @(negedge clk);
    #1;
    check("bub_beat_cnt", CW'(cnt_w[3]), CW'(4));
    check("bub_drain", CW'(exp_q[3].size()), CW'(0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/array_alu_pl.md
Name: array_alu_pl

Overview:
Parametrised successor to the cache-line element-wise adder. Takes two CACHE_WIDTH-bit cache lines, splits them into LANES = CACHE_WIDTH/DATA_WIDTH lanes and applies a selectable op per beat (add, sub, min, max) with optional saturation. Runs as a PIPE_STAGES-deep pipeline with valid/ready flow control and bubble collapsing. Sits between the CCI read-response path and the write-request path of the accelerator datapath.

Parameters:
CACHE_WIDTH, 512, line width in bits; must be a multiple of DATA_WIDTH.
DATA_WIDTH, 32, lane width in bits; one of 8/16/32/64.
PIPE_STAGES, 2, pipeline depth, >= 1; stage 0 computes, the rest are delay stages.
SIGNED, 0, 1 = two's-complement lanes for min/max/saturation; 0 = unsigned.
SATURATE, 0, 1 = add/sub clamp to lane range; 0 = wrap modulo 2^DATA_WIDTH.

Ports:
clk  input  1  clock
rst  input  1  reset, asynchronous, active-low
in_valid  input  1  beat present on in_*
in_ready  output  1  block accepts beat this cycle
in_op  input  2  00 add, 01 sub (a-b), 10 min, 11 max
in_a  input  CACHE_WIDTH  operand line A
in_b  input  CACHE_WIDTH  operand line B
out_valid  output  1  result present
out_ready  input  1  consumer accepts result
out_res  output  CACHE_WIDTH  result line
out_ovf  output  LANES  per-lane overflow/clamp flag (add/sub only)
beat_cnt  output  32  completed output beats, wraps at 2^32

Behaviour:
- Reset (rst=0, async): all stage valids, out_valid, out_res, out_ovf, beat_cnt clear to 0; in_ready returns 1 one cycle after rst deasserts. Data regs also cleared.
- Handshake: input transfer on in_valid && in_ready; output transfer on out_valid && out_ready. out_res/out_ovf hold stable while out_valid && !out_ready.
- Stage k loads when stage k is empty or stage k advances; stage k advances when stage k+1 is empty or advances; the last stage advances on out_ready. in_ready = stage-0 load condition (combinational from out_ready through the valid chain). Bubbles collapse: an empty stage is filled even while downstream is stalled.
- Latency: PIPE_STAGES cycles from input transfer to out_valid with out_ready held 1. Throughput 1 beat/cycle.
- Full: all stages valid and out_ready=0 -> in_ready=0; next cycle with out_ready=1 accepts a new beat in the same cycle (no dead cycle).
- Lane i = bits [i*DATA_WIDTH +: DATA_WIDTH]; lanes independent, no carry across lanes.
- Add/sub computed at DATA_WIDTH+1 bits. Overflow: unsigned = carry/borrow out; signed = sign overflow. SATURATE=1 clamps to max/min of lane range, out_ovf[i]=1; SATURATE=0 wraps, out_ovf[i]=1 still reported.
- Min/max: compare per SIGNED; ties return a; out_ovf=0.
- beat_cnt increments on each output transfer; wraps 0xFFFFFFFF->0.
- Reset mid-operation: in-flight beats are discarded, no output transfer completes for them.
- Undefined in_op values impossible (2-bit fully decoded).

Decomposition:
- Shared package: op encoding constants (OP_ADD, OP_SUB, OP_MIN, OP_MAX), LANES derivation, saturation limit helper functions.
- One sub-module: array_alu_lane (combinational single-lane op + overflow + clamp), instantiated LANES times by generate in stage 0.

Test Plan:
- Add, defaults: a lanes all 5, b lanes all 7, op=00, out_ready=1 -> out_valid 2 cycles later, all lanes 12, out_ovf=0, beat_cnt=1.
- Unsigned wrap vs saturate: lane0 a=0xFFFFFFFF, b=2, add -> SATURATE=0: 0x00000001, ovf[0]=1; SATURATE=1: 0xFFFFFFFF, ovf[0]=1; other lanes unaffected.
- Signed sub/min: SIGNED=1, lane0 a=0x80000000, b=1, sub, SATURATE=1 -> 0x80000000, ovf[0]=1; min of a=-3 (0xFFFFFFFD), b=4 -> 0xFFFFFFFD; SIGNED=0 same min -> 4.
- Backpressure: stream 8 beats, out_ready=0 for cycles 3-10 -> in_ready drops after PIPE_STAGES beats held, no beat lost or duplicated, order preserved, beat_cnt=8 at end.
- Bubble collapse: PIPE_STAGES=4, one beat then idle then one beat, out_ready=0 -> both beats packed in last two stages, in_ready stays 1 for 2 more beats.
- Async reset mid-stream: drop rst with 3 beats in flight -> out_valid=0 and beat_cnt=0 immediately (no clock edge needed), no stale beat emerges after release.
